// File: rtl/serial_sub_pkg.sv
// serial_subtractor shared types and helpers.
// Optional signed-overflow output: define SERIAL_SUB_OVF_EN.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Slice counter width: clog2(n), never below 1.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_subtractor_sub_slice.sv
// Combinational ripple-borrow subtractor for one slice.
// SERIAL_SUB_OVF_EN adds bmsb_s, the borrow into the slice MSB.
module sub_slice #(
  parameter int BITS = 1
) (
  input  logic [BITS-1:0] a_s,
  input  logic [BITS-1:0] b_s,
  input  logic            bin_s,
  output logic [BITS-1:0] d_s,
  output logic            bout_s
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic            bmsb_s
`endif
);

  logic [BITS:0] bw;

  assign bw[0] = bin_s;

  for (genvar i = 0; i < BITS; i++) begin : g_bit
    assign d_s[i]    = a_s[i] ^ b_s[i] ^ bw[i];
    assign bw[i+1]   = (~a_s[i] & b_s[i])
                     | (~(a_s[i] ^ b_s[i]) & bw[i]);
  end

  assign bout_s = bw[BITS];

`ifdef SERIAL_SUB_OVF_EN
  assign bmsb_s = bw[BITS-1];
`endif

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle a - b - bin, BITS_PER_CYCLE bits per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to add the registered ovf output.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int BPC = BITS_PER_CYCLE;
  localparam int N   = WIDTH / BPC;
  localparam int CW  = cnt_width(N);

  if (BPC < 1 || WIDTH < 2 || (WIDTH % BPC) != 0) begin : g_bad_cfg
    $fatal(1, "serial_subtractor: WIDTH>=2 and BITS_PER_CYCLE | WIDTH");
  end

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic           br_q, br_d;
  logic           bout_q, bout_d;

  logic [BPC-1:0] d_s;
  logic           bo_s;
  logic           last;
  logic [WIDTH+BPC-1:0] res_cat;

`ifdef SERIAL_SUB_OVF_EN
  logic bmsb_s;
  logic ovf_q, ovf_d;
`endif

  sub_slice #(
    .BITS (BPC)
  ) u_slice (
    .a_s    (a_q[BPC-1:0]),
    .b_s    (b_q[BPC-1:0]),
    .bin_s  (br_q),
    .d_s    (d_s),
    .bout_s (bo_s)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .bmsb_s (bmsb_s)
`endif
  );

  assign last    = (cnt_q == CW'(N - 1));
  assign res_cat = {d_s, res_q};

  // Next-state: accept in IDLE/DONE, shift one slice per BUSY cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    res_d   = res_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) state_d = IDLE;
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          res_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        a_d   = a_q >> BPC;
        b_d   = b_q >> BPC;
        br_d  = bo_s;
        res_d = res_cat[WIDTH+BPC-1:BPC];
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          diff_d  = res_cat[WIDTH+BPC-1:BPC];
          bout_d  = bo_s;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = bmsb_s ^ bo_s;
`endif
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      res_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == BUSY);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
